// File: rtl/unified_cache_tag_array.sv
// Tag array for the unified cache: tag/valid/round-robin storage, evict reporting, flush sequencer.
// Optional per-entry even parity is enabled with `define UNIFIED_CACHE_TAG_PARITY_EN.
module unified_cache_tag_array #(
    parameter int unsigned SINGLE_TAG_SIZE_IN_BITS = 20,
    parameter int unsigned NUMBER_WAYS             = 4,
    parameter int unsigned NUMBER_SETS             = 16,
    parameter int unsigned SET_PTR_WIDTH_IN_BITS   = 4,
    parameter int unsigned WAY_PTR_WIDTH_IN_BITS   = 2
) (
    input  logic                                           clk_in,
    input  logic                                           reset_in,
    input  logic [NUMBER_WAYS-1:0]                         way_select_in,
    input  logic                                           read_en_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]               read_set_addr_in,
    output logic                                           read_valid_out,
    output logic [SINGLE_TAG_SIZE_IN_BITS*NUMBER_WAYS-1:0] read_pack_out,
    output logic [NUMBER_WAYS-1:0]                         read_valid_pack_out,
    output logic [NUMBER_WAYS-1:0]                         parity_error_out,
    input  logic                                           write_en_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]               write_set_addr_in,
    input  logic [SINGLE_TAG_SIZE_IN_BITS-1:0]             write_tag_in,
    output logic                                           write_done_out,
    output logic [NUMBER_WAYS-1:0]                         evict_way_out,
    output logic [SINGLE_TAG_SIZE_IN_BITS-1:0]             evict_tag_out,
    output logic                                           evict_valid_out,
    input  logic                                           flush_in,
    output logic                                           busy_out
);

    localparam logic [SET_PTR_WIDTH_IN_BITS-1:0] LAST_SET =
        SET_PTR_WIDTH_IN_BITS'(NUMBER_SETS - 1);

    typedef enum logic [0:0] {StIdle, StFlush} state_e;

    state_e                           state_q, state_d;
    logic [SET_PTR_WIDTH_IN_BITS-1:0] flush_set_q, flush_set_d;

    logic [SINGLE_TAG_SIZE_IN_BITS-1:0] tag_mem_q [NUMBER_SETS][NUMBER_WAYS];
    logic [NUMBER_WAYS-1:0]             valid_q   [NUMBER_SETS];
    logic [WAY_PTR_WIDTH_IN_BITS-1:0]   rr_ptr_q  [NUMBER_SETS];
`ifdef UNIFIED_CACHE_TAG_PARITY_EN
    logic [NUMBER_WAYS-1:0]             parity_q  [NUMBER_SETS];
`endif

    logic                                           idle, read_acc, write_acc, use_rr;
    logic [NUMBER_WAYS-1:0]                         wr_set_valid, victim_onehot;
    logic [WAY_PTR_WIDTH_IN_BITS-1:0]               victim_idx;
    logic [SINGLE_TAG_SIZE_IN_BITS*NUMBER_WAYS-1:0] rd_pack;
    logic [NUMBER_WAYS-1:0]                         rd_valid, rd_perr;

    // ------------------------------------------------------------------ flush FSM
    always_comb begin
        state_d     = state_q;
        flush_set_d = flush_set_q;
        case (state_q)
            StIdle: begin
                if (flush_in) begin
                    state_d     = StFlush;
                    flush_set_d = '0;
                end
            end
            StFlush: begin
                flush_set_d = flush_set_q + 1'b1;
                if (flush_set_q == LAST_SET) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign idle      = (state_q == StIdle);
    assign busy_out  = (state_q == StFlush);
    assign read_acc  = read_en_in & idle;
    assign write_acc = write_en_in & idle;

    // ------------------------------------------------------------------ victim select
    always_comb begin
        wr_set_valid = valid_q[write_set_addr_in];
        victim_idx   = rr_ptr_q[write_set_addr_in];
        use_rr       = 1'b1;
        // Downward scans so the lowest matching index wins.
        if (|way_select_in) begin
            use_rr = 1'b0;
            for (int i = NUMBER_WAYS - 1; i >= 0; i--) begin
                if (way_select_in[i]) victim_idx = WAY_PTR_WIDTH_IN_BITS'(i);
            end
        end else if (!(&wr_set_valid)) begin
            use_rr = 1'b0;
            for (int i = NUMBER_WAYS - 1; i >= 0; i--) begin
                if (!wr_set_valid[i]) victim_idx = WAY_PTR_WIDTH_IN_BITS'(i);
            end
        end
        victim_onehot = NUMBER_WAYS'(1) << victim_idx;
    end

    // ------------------------------------------------------------------ read path
    always_comb begin
        rd_valid = valid_q[read_set_addr_in];
        rd_perr  = '0;
        for (int w = 0; w < NUMBER_WAYS; w++) begin
            rd_pack[w*SINGLE_TAG_SIZE_IN_BITS +: SINGLE_TAG_SIZE_IN_BITS] =
                tag_mem_q[read_set_addr_in][w];
`ifdef UNIFIED_CACHE_TAG_PARITY_EN
            rd_perr[w] = rd_valid[w] &
                ((^tag_mem_q[read_set_addr_in][w]) != parity_q[read_set_addr_in][w]);
`endif
        end
        // Write-first bypass: a same-set write is visible to the concurrent read.
        if (write_acc && (write_set_addr_in == read_set_addr_in)) begin
            rd_pack[victim_idx*SINGLE_TAG_SIZE_IN_BITS +: SINGLE_TAG_SIZE_IN_BITS] = write_tag_in;
            rd_valid[victim_idx] = 1'b1;
            rd_perr[victim_idx]  = 1'b0;
        end
    end

    // ------------------------------------------------------------------ tag storage
    always_ff @(posedge clk_in) begin
        if (write_acc) begin
            tag_mem_q[write_set_addr_in][victim_idx] <= write_tag_in;
`ifdef UNIFIED_CACHE_TAG_PARITY_EN
            parity_q[write_set_addr_in][victim_idx]  <= ^write_tag_in;
`endif
        end
    end

    // ------------------------------------------------------------------ state and outputs
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q             <= StIdle;
            flush_set_q         <= '0;
            for (int s = 0; s < NUMBER_SETS; s++) begin
                valid_q[s]  <= '0;
                rr_ptr_q[s] <= '0;
            end
            read_valid_out      <= 1'b0;
            read_pack_out       <= '0;
            read_valid_pack_out <= '0;
            parity_error_out    <= '0;
            write_done_out      <= 1'b0;
            evict_way_out       <= '0;
            evict_tag_out       <= '0;
            evict_valid_out     <= 1'b0;
        end else begin
            state_q        <= state_d;
            flush_set_q    <= flush_set_d;
            read_valid_out <= read_acc;
            write_done_out <= write_acc;
            if (busy_out) begin
                valid_q[flush_set_q] <= '0;
            end
            if (write_acc) begin
                valid_q[write_set_addr_in][victim_idx] <= 1'b1;
                if (use_rr) begin
                    rr_ptr_q[write_set_addr_in] <= rr_ptr_q[write_set_addr_in] + 1'b1;
                end
                evict_way_out   <= victim_onehot;
                evict_tag_out   <= tag_mem_q[write_set_addr_in][victim_idx];
                evict_valid_out <= wr_set_valid[victim_idx];
            end
            if (read_acc) begin
                read_pack_out       <= rd_pack;
                read_valid_pack_out <= rd_valid & ~rd_perr;
                parity_error_out    <= rd_perr;
            end
        end
    end

endmodule

// File: tb/tb_unified_cache_tag_array.sv
// Directed vector-table bench for unified_cache_tag_array, plus flush, reset-abort and parity sequences.
module tb_unified_cache_tag_array;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic [3:0]  way_select_in;
    logic        read_en_in;
    logic [3:0]  read_set_addr_in;
    logic        read_valid_out;
    logic [79:0] read_pack_out;
    logic [3:0]  read_valid_pack_out;
    logic [3:0]  parity_error_out;
    logic        write_en_in;
    logic [3:0]  write_set_addr_in;
    logic [19:0] write_tag_in;
    logic        write_done_out;
    logic [3:0]  evict_way_out;
    logic [19:0] evict_tag_out;
    logic        evict_valid_out;
    logic        flush_in;
    logic        busy_out;

    int checks = 0;
    int errors = 0;

    unified_cache_tag_array dut (
        .clk_in              (clk_in),
        .reset_in            (reset_in),
        .way_select_in       (way_select_in),
        .read_en_in          (read_en_in),
        .read_set_addr_in    (read_set_addr_in),
        .read_valid_out      (read_valid_out),
        .read_pack_out       (read_pack_out),
        .read_valid_pack_out (read_valid_pack_out),
        .parity_error_out    (parity_error_out),
        .write_en_in         (write_en_in),
        .write_set_addr_in   (write_set_addr_in),
        .write_tag_in        (write_tag_in),
        .write_done_out      (write_done_out),
        .evict_way_out       (evict_way_out),
        .evict_tag_out       (evict_tag_out),
        .evict_valid_out     (evict_valid_out),
        .flush_in            (flush_in),
        .busy_out            (busy_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        rd_en;
        logic [3:0]  rd_set;
        logic        chk_slice;
        logic [1:0]  slice;
        logic [19:0] slice_tag;
        logic [3:0]  exp_vpack;
        logic        wr_en;
        logic [3:0]  wr_set;
        logic [19:0] wr_tag;
        logic [3:0]  way_sel;
        logic [3:0]  exp_ev_way;
        logic        exp_ev_valid;
        logic [19:0] exp_ev_tag;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rd_en, input logic [3:0] rd_set, input logic chk_slice,
                                input logic [1:0] slice, input logic [19:0] slice_tag,
                                input logic [3:0] exp_vpack, input logic wr_en,
                                input logic [3:0] wr_set, input logic [19:0] wr_tag,
                                input logic [3:0] way_sel, input logic [3:0] exp_ev_way,
                                input logic exp_ev_valid, input logic [19:0] exp_ev_tag);
        vec_t v;
        v.rd_en = rd_en; v.rd_set = rd_set; v.chk_slice = chk_slice; v.slice = slice;
        v.slice_tag = slice_tag; v.exp_vpack = exp_vpack; v.wr_en = wr_en; v.wr_set = wr_set;
        v.wr_tag = wr_tag; v.way_sel = way_sel; v.exp_ev_way = exp_ev_way;
        v.exp_ev_valid = exp_ev_valid; v.exp_ev_tag = exp_ev_tag;
        return v;
    endfunction

    task automatic clear_inputs();
        read_en_in = 0; write_en_in = 0; flush_in = 0; way_select_in = '0;
        read_set_addr_in = '0; write_set_addr_in = '0; write_tag_in = '0;
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    int busy_cnt;

    initial begin
        clear_inputs();
        reset_in = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;
        check("reset read_valid", 64'(read_valid_out), 64'd0);
        check("reset write_done", 64'(write_done_out), 64'd0);
        check("reset busy", 64'(busy_out), 64'd0);
        check("reset evict_way", 64'(evict_way_out), 64'd0);
        check("reset evict_valid", 64'(evict_valid_out), 64'd0);
        check("reset vpack", 64'(read_valid_pack_out), 64'd0);
        @(negedge clk_in);
        reset_in = 1'b0;

        // rd_en rd_set chk slice tag vpack | wr_en wr_set tag way_sel ev_way ev_valid ev_tag
        vecs.push_back(mk(1, 3, 0, 0, 0,        4'b0000, 0, 0, 0,        4'b0000, 0,       0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,        0,       1, 5, 20'h12345, 4'b0000, 4'b0001, 0, 0));
        vecs.push_back(mk(1, 5, 1, 0, 20'h12345, 4'b0001, 0, 0, 0,        4'b0000, 0,       0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,        0,       1, 6, 20'h00001, 4'b0000, 4'b0001, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,        0,       1, 6, 20'h00002, 4'b0000, 4'b0010, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,        0,       1, 6, 20'h00003, 4'b0000, 4'b0100, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,        0,       1, 6, 20'h00004, 4'b0000, 4'b1000, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,        0,       1, 6, 20'hABCDE, 4'b0000, 4'b0001, 1, 20'h00001));
        vecs.push_back(mk(0, 0, 0, 0, 0,        0,       1, 6, 20'h55555, 4'b0000, 4'b0010, 1, 20'h00002));
        vecs.push_back(mk(0, 0, 0, 0, 0,        0,       1, 6, 20'h77777, 4'b0100, 4'b0100, 1, 20'h00003));
        vecs.push_back(mk(0, 0, 0, 0, 0,        0,       1, 6, 20'h99999, 4'b0000, 4'b0100, 1, 20'h77777));
        vecs.push_back(mk(0, 0, 0, 0, 0,        0,       1, 6, 20'h0AAAA, 4'b1010, 4'b0010, 1, 20'h55555));
        vecs.push_back(mk(1, 6, 1, 1, 20'h0AAAA, 4'b1111, 0, 0, 0,        4'b0000, 0,       0, 0));
        vecs.push_back(mk(1, 6, 1, 2, 20'h99999, 4'b1111, 1, 8, 20'h00888, 4'b0000, 4'b0001, 0, 0));
        vecs.push_back(mk(1, 8, 1, 0, 20'h00888, 4'b0001, 0, 0, 0,        4'b0000, 0,       0, 0));
        vecs.push_back(mk(1, 7, 1, 2, 20'h0BEEF, 4'b0100, 1, 7, 20'h0BEEF, 4'b0100, 4'b0100, 0, 0));
        vecs.push_back(mk(1, 6, 1, 0, 20'hABCDE, 4'b1111, 0, 0, 0,        4'b0000, 0,       0, 0));

        @(posedge clk_in);
        #1;
        foreach (vecs[i]) begin
            read_en_in        = vecs[i].rd_en;
            read_set_addr_in  = vecs[i].rd_set;
            write_en_in       = vecs[i].wr_en;
            write_set_addr_in = vecs[i].wr_set;
            write_tag_in      = vecs[i].wr_tag;
            way_select_in     = vecs[i].way_sel;
            tick();
            check($sformatf("v%0d read_valid", i), 64'(read_valid_out), 64'(vecs[i].rd_en));
            check($sformatf("v%0d write_done", i), 64'(write_done_out), 64'(vecs[i].wr_en));
            if (vecs[i].rd_en) begin
                check($sformatf("v%0d vpack", i), 64'(read_valid_pack_out), 64'(vecs[i].exp_vpack));
                check($sformatf("v%0d perr", i), 64'(parity_error_out), 64'd0);
                if (vecs[i].chk_slice)
                    check($sformatf("v%0d slice%0d", i, vecs[i].slice),
                          64'(read_pack_out[vecs[i].slice*20 +: 20]), 64'(vecs[i].slice_tag));
            end
            if (vecs[i].wr_en) begin
                check($sformatf("v%0d evict_way", i), 64'(evict_way_out), 64'(vecs[i].exp_ev_way));
                check($sformatf("v%0d evict_valid", i), 64'(evict_valid_out),
                      64'(vecs[i].exp_ev_valid));
                if (vecs[i].exp_ev_valid)
                    check($sformatf("v%0d evict_tag", i), 64'(evict_tag_out),
                          64'(vecs[i].exp_ev_tag));
            end
            clear_inputs();
        end

        // Flush together with a write: the write is serviced, then the flush runs.
        flush_in = 1; write_en_in = 1; write_set_addr_in = 2; write_tag_in = 20'h22222;
        tick();
        clear_inputs();
        check("flush+write done", 64'(write_done_out), 64'd1);
        check("flush+write way", 64'(evict_way_out), 64'b0001);
        check("flush busy first", 64'(busy_out), 64'd1);
        busy_cnt = busy_out ? 1 : 0;
        for (int c = 0; c < 40; c++) begin
            if (c == 4) begin
                write_en_in = 1; write_set_addr_in = 0; write_tag_in = 20'h0F00D;
                read_en_in = 1; read_set_addr_in = 6;
            end
            if (c == 6) flush_in = 1;
            tick();
            if (c == 4) begin
                check("mid-flush write_done", 64'(write_done_out), 64'd0);
                check("mid-flush read_valid", 64'(read_valid_out), 64'd0);
            end
            clear_inputs();
            if (!busy_out) break;
            busy_cnt++;
        end
        check("flush busy cycles", 64'(busy_cnt), 64'd16);
        for (int s = 0; s < 16; s++) begin
            read_en_in = 1; read_set_addr_in = 4'(s);
            tick();
            check($sformatf("post-flush set%0d read_valid", s), 64'(read_valid_out), 64'd1);
            check($sformatf("post-flush set%0d vpack", s), 64'(read_valid_pack_out), 64'd0);
        end
        clear_inputs();
        tick();

        // Reset in the middle of a flush returns to idle.
        flush_in = 1;
        tick();
        flush_in = 0;
        check("second flush busy", 64'(busy_out), 64'd1);
        tick();
        reset_in = 1;
        #1;
        check("reset abort busy", 64'(busy_out), 64'd0);
        @(negedge clk_in);
        reset_in = 0;
        tick();
        check("after abort busy", 64'(busy_out), 64'd0);

        // Parity: corrupt one stored bit of set 1 way 2.
        write_en_in = 1; write_set_addr_in = 1; write_tag_in = 20'h13579; way_select_in = 4'b0100;
        tick();
        clear_inputs();
        check("parity write way", 64'(evict_way_out), 64'b0100);
`ifdef UNIFIED_CACHE_TAG_PARITY_EN
        dut.tag_mem_q[1][2] = dut.tag_mem_q[1][2] ^ 20'h00010;
        read_en_in = 1; read_set_addr_in = 1;
        tick();
        clear_inputs();
        check("parity err", 64'(parity_error_out), 64'b0100);
        check("parity vpack", 64'(read_valid_pack_out), 64'b0000);
`else
        read_en_in = 1; read_set_addr_in = 1;
        tick();
        clear_inputs();
        check("no-parity err", 64'(parity_error_out), 64'b0000);
        check("no-parity vpack", 64'(read_valid_pack_out), 64'b0100);
        check("no-parity slice2", 64'(read_pack_out[40 +: 20]), 64'h13579);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
